// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// fetch_queue: IF->ID instruction queue with valid/ready handshakes and flush.
// Revision: 1.0
// ============================================================================
module fetch_queue #(
  parameter int INSN_W = 32,
  parameter int PC_W   = 32,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [INSN_W-1:0]          in_insn,
  input  logic [PC_W-1:0]            in_pc_plus4,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [INSN_W-1:0]          out_insn,
  output logic [PC_W-1:0]            out_pc_plus4,
  input  logic                       flush,
  output logic [$clog2(DEPTH):0]     count,
  output logic [CNT_W-1:0]           flush_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] c_DEPTH = OCC_W'(DEPTH);

  logic [INSN_W-1:0] r_insn_mem [DEPTH];
  logic [PC_W-1:0]   r_pc_mem   [DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [OCC_W-1:0]  r_count;
  logic [CNT_W-1:0]  r_flush_cnt;

  logic w_full;
  logic w_empty;
  logic w_enq;
  logic w_deq;
  logic w_flush_hit;

  assign w_full  = (r_count == c_DEPTH);
  assign w_empty = (r_count == '0);
  assign w_enq   = in_valid && !w_full && !flush;
  assign w_deq   = !w_empty && out_ready && !flush;
  // A flush only counts when it actually throws work away.
  assign w_flush_hit = flush && (!w_empty || (in_valid && !w_full));

  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_insn_mem[r_wr_ptr] <= in_insn;
      r_pc_mem[r_wr_ptr]   <= in_pc_plus4;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_flush_hit && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
      if (flush) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_enq) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        if (w_deq) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        if (w_enq && !w_deq)      r_count <= r_count + OCC_W'(1);
        else if (w_deq && !w_enq) r_count <= r_count - OCC_W'(1);
      end
    end
  end

  assign in_ready     = !w_full;
  assign out_valid    = !w_empty;
  assign out_insn     = w_empty ? '0 : r_insn_mem[r_rd_ptr];
  assign out_pc_plus4 = w_empty ? '0 : r_pc_mem[r_rd_ptr];
  assign count        = r_count;
  assign flush_cnt    = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// Bench for fetch_queue: directed scenarios then random traffic against a queue model.
module tb_fetch_queue;
  localparam int DEPTH = 4;
  localparam int CNT_W = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_insn;
  logic [31:0] in_pc_plus4;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_insn;
  logic [31:0] out_pc_plus4;
  logic        flush;
  logic [2:0]  count;
  logic [CNT_W-1:0] flush_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] m_q[$];
  int          m_fc = 0;
  logic [CNT_W-1:0] saved_fc;

  always #5 clk = ~clk;

  fetch_queue #(.INSN_W(32), .PC_W(32), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_insn(in_insn), .in_pc_plus4(in_pc_plus4),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_insn(out_insn), .out_pc_plus4(out_pc_plus4),
    .flush(flush), .count(count), .flush_cnt(flush_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string ctx);
    logic [63:0] head;
    head = (m_q.size() != 0) ? m_q[0] : 64'h0;
    chk({ctx, ".out_valid"}, 64'(out_valid), 64'(m_q.size() != 0));
    chk({ctx, ".in_ready"},  64'(in_ready),  64'(m_q.size() != DEPTH));
    chk({ctx, ".count"},     64'(count),     64'(m_q.size()));
    chk({ctx, ".out_insn"},  64'(out_insn),  64'(head[31:0]));
    chk({ctx, ".out_pc"},    64'(out_pc_plus4), 64'(head[63:32]));
    chk({ctx, ".flush_cnt"}, 64'(flush_cnt), 64'(m_fc));
  endtask

  task automatic drive(input logic v, input logic [31:0] insn, input logic rdy, input logic fl);
    in_valid    = v;
    in_insn     = insn;
    in_pc_plus4 = insn ^ 32'h0040_0004;
    out_ready   = rdy;
    flush       = fl;
  endtask

  // One clock: check current outputs against the model, then advance both.
  task automatic step(input string ctx, input logic v, input logic [31:0] insn,
                      input logic rdy, input logic fl);
    bit acc, pop;
    drive(v, insn, rdy, fl);
    #1;
    check_model(ctx);
    acc = v && (m_q.size() < DEPTH);
    pop = rdy && (m_q.size() > 0);
    if (fl) begin
      if ((m_q.size() > 0 || acc) && m_fc < (2**CNT_W - 1)) m_fc++;
      m_q.delete();
    end else begin
      if (pop) void'(m_q.pop_front());
      if (acc) m_q.push_back({insn ^ 32'h0040_0004, insn});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] fill_vals [4];
    fill_vals[0] = 32'h11; fill_vals[1] = 32'h22; fill_vals[2] = 32'h33; fill_vals[3] = 32'h44;

    reset = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.in_ready", 64'(in_ready), 64'd1);
    chk("rst.count", 64'(count), 64'd0);
    chk("rst.out_insn", 64'(out_insn), 64'd0);
    chk("rst.flush_cnt", 64'(flush_cnt), 64'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Fill to full, then a rejected fifth entry, then drain in order.
    for (int i = 0; i < 4; i++) step("fill", 1'b1, fill_vals[i], 1'b0, 1'b0);
    chk("full.count", 64'(count), 64'd4);
    chk("full.in_ready", 64'(in_ready), 64'd0);
    step("fifth", 1'b1, 32'h55, 1'b0, 1'b0);
    chk("fifth.count", 64'(count), 64'd4);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      #1;
      chk("drain.insn", 64'(out_insn), 64'(fill_vals[i]));
      step("drain", 1'b0, 32'h0, 1'b1, 1'b0);
    end
    chk("drained.valid", 64'(out_valid), 64'd0);
    chk("drained.insn", 64'(out_insn), 64'd0);

    // Flush with a same-cycle enqueue pending.
    for (int i = 0; i < 3; i++) step("pre_flush", 1'b1, 32'h100 + i, 1'b0, 1'b0);
    step("flush_dead", 1'b1, 32'hDEAD, 1'b0, 1'b1);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    chk("flush.count", 64'(count), 64'd0);
    chk("flush.valid", 64'(out_valid), 64'd0);
    chk("flush.insn", 64'(out_insn), 64'd0);
    chk("flush.flush_cnt", 64'(flush_cnt), 64'd1);
    step("post_flush", 1'b1, 32'h777, 1'b0, 1'b0);
    chk("post_flush.count", 64'(count), 64'd1);
    step("post_flush_pop", 1'b0, 32'h0, 1'b1, 1'b0);

    // Flush of an already-empty queue does not count.
    saved_fc = flush_cnt;
    step("empty_flush", 1'b0, 32'h0, 1'b0, 1'b1);
    chk("empty_flush.cnt", 64'(flush_cnt), 64'(saved_fc));

    // Load-use hold: lw stays at the head while add queues behind it.
    step("lw", 1'b1, 32'h8C01_0000, 1'b0, 1'b0);
    step("hold1", 1'b1, 32'h0022_1820, 1'b0, 1'b0);
    step("hold2", 1'b0, 32'h0, 1'b0, 1'b0);
    chk("hold.head", 64'(out_insn), 64'h8C01_0000);
    chk("hold.count", 64'(count), 64'd2);
    step("rel_lw", 1'b0, 32'h0, 1'b1, 1'b0);
    chk("rel.add", 64'(out_insn), 64'h0022_1820);
    step("rel_add", 1'b0, 32'h0, 1'b1, 1'b0);

    // Steady state at count=2 with enqueue and dequeue every cycle.
    step("sim_pre0", 1'b1, 32'hF0, 1'b0, 1'b0);
    step("sim_pre1", 1'b1, 32'hF1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'(i), 1'b1, 1'b0);
      #1;
      chk("sim.count", 64'(count), 64'd2);
      chk("sim.head", 64'(out_insn), (i < 2) ? 64'(32'hF0 + i) : 64'(i - 2));
      step("sim", 1'b1, 32'(i), 1'b1, 1'b0);
    end
    step("sim_tail0", 1'b0, 32'h0, 1'b1, 1'b0);
    step("sim_tail1", 1'b0, 32'h0, 1'b1, 1'b0);

    // Asynchronous reset between edges with three entries in flight.
    for (int i = 0; i < 3; i++) step("pre_rst", 1'b1, 32'h200 + i, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk("arst.out_valid", 64'(out_valid), 64'd0);
    chk("arst.in_ready", 64'(in_ready), 64'd1);
    chk("arst.count", 64'(count), 64'd0);
    chk("arst.flush_cnt", 64'(flush_cnt), 64'd0);
    m_q.delete();
    m_fc = 0;
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Random traffic including frequent flushes to reach counter saturation.
    for (int i = 0; i < 600; i++) begin
      step("rand", ($urandom % 4) != 0, $urandom, ($urandom % 3) != 0, ($urandom % 12) == 0);
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    check_model("final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
